// File: rtl/pipe_controller.sv
// Purpose : ID-stage decoder plus ID/EX, EX/MEM and MEM/WB control registers, with load-use hazard, forwarding and branch/jump flush control.
// Latency : bundle decoded at edge n is visible on ex_* in cycle n+1, mem_* in n+2 and wb_* in n+3; stall/flush/jump/illegal are combinational.
// Backpres: no handshake; stall holds PC and IF/ID for one cycle while a bubble enters EX, and a taken branch bubbles EX and flushes IF/ID.
// Ports   : clk, rst_n (sync, active-low); instr_id (IF/ID instruction); alu_zero_ex (EX ALU zero flag);
//           stall, flush_ifid, jump_id, pc_src_ex, illegal_id (ID/EX hazard and PC control);
//           ex_alucontrol, ex_alu_src, fwd_a, fwd_b (EX); mem_write_m (MEM); wb_reg_write, wb_mem_to_reg, wb_dest (WB).
module pipe_controller #(
  parameter int OPCODE_W  = 6,
  parameter int ALUCTRL_W = 4,
  parameter int REG_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr_id,
  input  logic                 alu_zero_ex,
  output logic                 stall,
  output logic                 flush_ifid,
  output logic                 jump_id,
  output logic                 pc_src_ex,
  output logic                 illegal_id,
  output logic [ALUCTRL_W-1:0] ex_alucontrol,
  output logic                 ex_alu_src,
  output logic [1:0]           fwd_a,
  output logic [1:0]           fwd_b,
  output logic                 mem_write_m,
  output logic                 wb_reg_write,
  output logic                 wb_mem_to_reg,
  output logic [REG_W-1:0]     wb_dest
);

  typedef struct packed {
    logic                 reg_write;
    logic                 mem_to_reg;
    logic                 mem_write;
    logic                 alu_src;
    logic                 beq;
    logic                 bne;
    logic [ALUCTRL_W-1:0] alu;
    logic [REG_W-1:0]     dest;
    logic [REG_W-1:0]     rs;
    logic [REG_W-1:0]     rt;
  } idex_t;

  typedef struct packed {
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_write;
    logic [REG_W-1:0] dest;
  } exmem_t;

  typedef struct packed {
    logic             reg_write;
    logic             mem_to_reg;
    logic [REG_W-1:0] dest;
  } memwb_t;

  logic [OPCODE_W-1:0] opcode;
  logic [REG_W-1:0]    rs_id, rt_id, rd_id;
  assign opcode = instr_id[31:32-OPCODE_W];
  assign rs_id  = instr_id[25 -: REG_W];
  assign rt_id  = instr_id[20 -: REG_W];
  assign rd_id  = instr_id[15 -: REG_W];

  idex_t  dec, id_ex_d, id_ex_q;
  exmem_t ex_mem_d, ex_mem_q;
  memwb_t mem_wb_d, mem_wb_q;
  logic   is_j, reads_rs, reads_rt, load_use;

  // Decode. Illegal opcodes and j produce an all-zero bundle; rs is still
  // considered read by everything except j.
  always_comb begin
    dec        = '0;
    is_j       = 1'b0;
    reads_rs   = 1'b1;
    reads_rt   = 1'b0;
    illegal_id = (opcode > OPCODE_W'(16));
    case (opcode)
      OPCODE_W'(0), OPCODE_W'(3), OPCODE_W'(8), OPCODE_W'(9),
      OPCODE_W'(10), OPCODE_W'(12), OPCODE_W'(13): begin
        dec.reg_write = 1'b1;
        dec.dest      = rd_id;
        reads_rt      = 1'b1;
      end
      OPCODE_W'(1), OPCODE_W'(2), OPCODE_W'(11), OPCODE_W'(14), OPCODE_W'(15): begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.dest      = rt_id;
      end
      OPCODE_W'(5): begin
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        dec.dest       = rt_id;
      end
      OPCODE_W'(4): begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        reads_rt      = 1'b1;
      end
      OPCODE_W'(6):  begin dec.beq = 1'b1; reads_rt = 1'b1; end
      OPCODE_W'(16): begin dec.bne = 1'b1; reads_rt = 1'b1; end
      OPCODE_W'(7):  begin is_j = 1'b1; reads_rs = 1'b0; end
      default: ;
    endcase
    // Fill operation and operand fields only for instructions that enter EX.
    if (!illegal_id && !is_j) begin
      dec.alu = dec.bne ? ALUCTRL_W'(6) : ALUCTRL_W'(opcode);
      dec.rs  = rs_id;
      dec.rt  = rt_id;
    end
  end

  // Branch resolution and hazard control; an older taken branch overrides
  // both the load-use stall and a jump in ID.
  always_comb begin
    pc_src_ex  = (id_ex_q.beq & alu_zero_ex) | (id_ex_q.bne & ~alu_zero_ex);
    load_use   = id_ex_q.mem_to_reg && (id_ex_q.dest != '0) &&
                 ((reads_rs && rs_id == id_ex_q.dest) || (reads_rt && rt_id == id_ex_q.dest));
    stall      = load_use & ~pc_src_ex;
    jump_id    = is_j & ~pc_src_ex;
    flush_ifid = pc_src_ex | jump_id;
  end

  // Forwarding: EX/MEM result beats MEM/WB; r0 never forwards.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (ex_mem_q.reg_write && ex_mem_q.dest != '0 && ex_mem_q.dest == id_ex_q.rs)
      fwd_a = 2'b10;
    else if (mem_wb_q.reg_write && mem_wb_q.dest != '0 && mem_wb_q.dest == id_ex_q.rs)
      fwd_a = 2'b01;
    if (ex_mem_q.reg_write && ex_mem_q.dest != '0 && ex_mem_q.dest == id_ex_q.rt)
      fwd_b = 2'b10;
    else if (mem_wb_q.reg_write && mem_wb_q.dest != '0 && mem_wb_q.dest == id_ex_q.rt)
      fwd_b = 2'b01;
  end

  always_comb begin
    id_ex_d             = (stall || pc_src_ex) ? '0 : dec;
    ex_mem_d            = '0;
    ex_mem_d.reg_write  = id_ex_q.reg_write;
    ex_mem_d.mem_to_reg = id_ex_q.mem_to_reg;
    ex_mem_d.mem_write  = id_ex_q.mem_write;
    ex_mem_d.dest       = id_ex_q.dest;
    mem_wb_d            = '0;
    mem_wb_d.reg_write  = ex_mem_q.reg_write;
    mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
    mem_wb_d.dest       = ex_mem_q.dest;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign ex_alucontrol = id_ex_q.alu;
  assign ex_alu_src    = id_ex_q.alu_src;
  assign mem_write_m   = ex_mem_q.mem_write;
  assign wb_reg_write  = mem_wb_q.reg_write;
  assign wb_mem_to_reg = mem_wb_q.mem_to_reg;
  assign wb_dest       = mem_wb_q.dest;

endmodule
